prime_stream: RTL and testbench
===============================

# prime_stream

Sequencer and output buffer placed directly downstream of `primegen`. It issues single-cycle `go` pulses to the generator, captures each prime when the generator reports ready, and pushes it into a small FIFO exposed as a valid/ready stream. It discards the generator's post-reset seed value of 1. It also stops cleanly on generator error or on arithmetic wrap-around.

## Interface
- `WIDTH`, 16, prime width; must match the attached `primegen`.
- `DEPTH`, 4, FIFO entries; power of two, at least 2.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: high permits issuing new requests.
- `gen_go` out 1: go pulse to `primegen`.
- `gen_ready` in 1: `primegen` ready.
- `gen_error` in 1: `primegen` error.
- `gen_res` in WIDTH: `primegen` result.
- `out_valid` out 1: stream valid.
- `out_ready` in 1: stream ready from the consumer.
- `out_data` out WIDTH: head prime.
- `done` out 1: sticky; wrap-around detected.
- `error` out 1: sticky; generator error.
- `count` out WIDTH: primes pushed so far; saturates at all-ones.

## Operation
- **Reset values:** `gen_go`=0, `out_valid`=0, `out_data`=0, `done`=0, `error`=0, `count`=0. FIFO empty, `last`=0, state IDLE.
- **FSM states:** IDLE, ISSUE, WAIT_ACK, WAIT_RES, DONE, ERR.
- **IDLE → ISSUE:** when `enable` && FIFO not full && !`done` && !`error`.
- **ISSUE:** `gen_go`=1 for exactly this one cycle, then → WAIT_ACK. Only one request is ever in flight.
- **WAIT_ACK:** wait for `gen_ready`=0, then → WAIT_RES. `primegen` drops ready one cycle after sampling the go edge, so this normally takes 1 cycle.
- **WAIT_RES:**
  - `gen_error`=1 has priority: → ERR; `error`<=1; no push.
  - Else on `gen_ready`=1, capture `gen_res`:
    - If `gen_res` <= `last`: this is wrap-around. → DONE; `done`<=1; no push.
    - Otherwise push `gen_res`, set `last`<=`gen_res`, increment `count`, → IDLE.
- **DONE and ERR:** terminal until `rst`. The FIFO keeps draining normally.
- **Seed discard:** `last` resets to 0, so the first prime (2) passes the check. The generator's initial res=1 is never captured, because capture only happens in WAIT_RES.
- **Backpressure:** issue is gated on "not full". With one request in flight, a capture can never hit a full FIFO.
- **Stream handshake:** a pop occurs when `out_valid` && `out_ready`. Push and pop may occur in the same cycle at any occupancy. `out_data` is stable while `out_valid` && !`out_ready`.
- **`enable` dropped mid-request:** the in-flight request completes and its result is pushed; no further issue.
- **Comparison:** `gen_res` <= `last` is an unsigned WIDTH-bit compare.

## Timing
- `gen_go` is registered; it is high the cycle after ISSUE is entered from IDLE.
- FIFO is registered, not fall-through. A value pushed at edge N gives `out_valid`=1 and `out_data` valid after edge N, which is 1 cycle capture-to-output.
- Minimum request overhead is 3 cycles (ISSUE, WAIT_ACK, capture) plus the generator's compute time.
- `count`, `done` and `error` update on the same edge as the capture.
- `rst` asserted in any state returns all registers to reset values on the next edge and flushes the FIFO. Any generator request in flight is abandoned; `primegen` shares `rst`.

## Structure
- **Shared package `primogen_pkg`:** FSM state encodings (3-bit constants) and the default WIDTH.
- **Sub-module `sync_fifo`:**
  - Parameters: WIDTH, DEPTH.
  - Ports: `clk`, `rst`, `push`, `push_data`, `pop`, `full`, `empty`, `head`.
  - Pointers are log2(DEPTH)+1 bits, which disambiguates full from empty.
- The top level instantiates `sync_fifo`. The `primegen` instance stays in the integrating testbench/top.

## Test plan
- **Basic stream:** WIDTH=16, `enable`=1, `out_ready`=1, real `primegen` attached → `out_data` sequence 2,3,5,7,11,13,17,19; `count`=8; no 1 is ever emitted.
- **Backpressure:** DEPTH=4, `out_ready`=0 → exactly 4 pushes (2,3,5,7), `out_valid`=1, `gen_go` stays 0. Raising `out_ready` for 1 cycle pops 2, and exactly one new request is issued, pushing 11.
- **Wrap-around:** WIDTH=4 → stream 2,3,5,7,11,13. The generator then returns 1 → `done`=1, `count`=6, no further `gen_go`, and the FIFO drains all 6.
- **Error:** behavioural generator model asserts `gen_error` with `gen_ready` during the 3rd request → `error`=1, FIFO holds 2,3 only, no further `gen_go`.
- **Enable drop:** `enable` falls during WAIT_RES of the 2nd request → 3 is still pushed; no 3rd `gen_go` until `enable` rises again.
- **Reset mid-operation:** `rst` for 1 cycle during WAIT_RES with 2 entries buffered → all outputs at reset values next cycle, FIFO empty. The stream restarts at 2.

Source files
------------

// File: rtl/primogen_pkg.sv
// rtl/primogen_pkg.sv - shared FSM encodings and default width for the prime stream sequencer
package primogen_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_WAIT_RES = 3'd3,
        ST_DONE     = 3'd4,
        ST_ERR      = 3'd5
    } state_t;

endpackage

// File: rtl/prime_stream_if.sv
// rtl/prime_stream_if.sv - valid/ready output stream carrying captured primes
interface prime_stream_if #(
    parameter int WIDTH = 16
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - registered synchronous FIFO with extra pointer bit for full/empty
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_pop_ok;
    logic             w_push_ok;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop_ok  = pop && !empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO is legal then.
    assign w_push_ok = push && (!full || w_pop_ok);
    assign head      = r_mem[r_rd_ptr[AW-1:0]];

    // Storage and pointers; storage is cleared so the head reads zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr[AW-1:0]] <= push_data;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/prime_stream.sv
// rtl/prime_stream.sv - sequences primegen requests and buffers primes into an output stream
module prime_stream
    import primogen_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    output logic                 gen_go,
    input  logic                 gen_ready,
    input  logic                 gen_error,
    input  logic [WIDTH-1:0]     gen_res,
    prime_stream_if.master       strm,
    output logic                 done,
    output logic                 error,
    output logic [WIDTH-1:0]     count
);
    state_t           r_state;
    state_t           w_next;
    logic             r_gen_go;
    logic             r_done;
    logic             r_error;
    logic [WIDTH-1:0] r_last;
    logic [WIDTH-1:0] r_count;

    logic             w_start;
    logic             w_push;
    logic             w_set_done;
    logic             w_set_err;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic [WIDTH-1:0] w_head;

    assign gen_go         = r_gen_go;
    assign done           = r_done;
    assign error          = r_error;
    assign count          = r_count;
    assign strm.out_valid = !w_empty;
    assign strm.out_data  = w_head;
    assign w_pop          = !w_empty && strm.out_ready;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (gen_res),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head)
    );

    // Next-state logic; a capture that does not exceed the last prime means the generator wrapped.
    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_push     = 1'b0;
        w_set_done = 1'b0;
        w_set_err  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && !w_full && !r_done && !r_error) begin
                    w_next  = ST_ISSUE;
                    w_start = 1'b1;
                end
            end
            ST_ISSUE: begin
                w_next = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (!gen_ready) begin
                    w_next = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                if (gen_error) begin
                    w_next    = ST_ERR;
                    w_set_err = 1'b1;
                end else if (gen_ready) begin
                    if (gen_res <= r_last) begin
                        w_next     = ST_DONE;
                        w_set_done = 1'b1;
                    end else begin
                        w_next = ST_IDLE;
                        w_push = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_next = ST_DONE;
            end
            ST_ERR: begin
                w_next = ST_ERR;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State, go pulse and capture bookkeeping; go is registered so it is high exactly during ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_gen_go <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_last   <= '0;
            r_count  <= '0;
        end else begin
            r_state  <= w_next;
            r_gen_go <= w_start;
            if (w_set_done) begin
                r_done <= 1'b1;
            end
            if (w_set_err) begin
                r_error <= 1'b1;
            end
            if (w_push) begin
                r_last <= gen_res;
                if (r_count != '1) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_prime_stream.sv
// tb/tb_prime_stream.sv - randomized self-checking bench for prime_stream with a behavioural generator
module tb_prime_stream;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic             gen_go;
    logic             gen_ready;
    logic             gen_error;
    logic [WIDTH-1:0] gen_res;
    logic             done;
    logic             error;
    logic [WIDTH-1:0] count;

    prime_stream_if #(.WIDTH(WIDTH)) strm ();

    prime_stream #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .gen_go    (gen_go),
        .gen_ready (gen_ready),
        .gen_error (gen_error),
        .gen_res   (gen_res),
        .strm      (strm.master),
        .done      (done),
        .error     (error),
        .count     (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int next_prime(input int p);
        int c;
        bit is_p;
        c = p;
        do begin
            c++;
            is_p = (c >= 2);
            for (int d = 2; d * d <= c; d++) begin
                if (c % d == 0) is_p = 1'b0;
            end
        end while (!is_p);
        return c;
    endfunction

    // Behavioural generator: res=1 after reset, drops ready on go, returns the next prime
    // after a random latency, wraps to 1 past g_limit, raises error on request g_err_req.
    int g_lat_min = 1;
    int g_lat_max = 5;
    int g_err_req = 0;
    int g_limit   = 65535;
    int g_req;
    int g_cnt;
    bit g_busy;

    always @(posedge clk) begin
        if (rst) begin
            gen_ready <= 1'b1;
            gen_res   <= WIDTH'(1);
            gen_error <= 1'b0;
            g_busy    <= 1'b0;
            g_req     <= 0;
            g_cnt     <= 0;
        end else if (!g_busy) begin
            if (gen_go && gen_ready) begin
                gen_ready <= 1'b0;
                gen_error <= 1'b0;
                g_busy    <= 1'b1;
                g_req     <= g_req + 1;
                g_cnt     <= int'($urandom_range(g_lat_max, g_lat_min));
            end
        end else if (g_cnt > 0) begin
            g_cnt <= g_cnt - 1;
        end else begin
            g_busy    <= 1'b0;
            gen_ready <= 1'b1;
            gen_error <= (g_req == g_err_req);
            if (next_prime(int'(gen_res)) > g_limit) gen_res <= WIDTH'(1);
            else gen_res <= WIDTH'(next_prime(int'(gen_res)));
        end
    end

    // Stream monitor: records pops, counts go pulses, flags data changing while stalled.
    logic [WIDTH-1:0] got_q[$];
    int               go_cnt;
    int               stab_err;
    bit               prev_hold;
    logic [WIDTH-1:0] prev_data;

    always @(negedge clk) begin
        if (rst) begin
            got_q.delete();
            go_cnt    = 0;
            stab_err  = 0;
            prev_hold = 1'b0;
        end else begin
            if (gen_go) go_cnt++;
            if (prev_hold && strm.out_data !== prev_data) stab_err++;
            if (strm.out_valid && strm.out_ready) got_q.push_back(strm.out_data);
            prev_hold = strm.out_valid && !strm.out_ready;
            prev_data = strm.out_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic check_stream(input string tag, input int n);
        int p;
        p = 1;
        chk({tag, "_len"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            p = next_prime(p);
            chk($sformatf("%s_%0d", tag, i), got_q[i], p);
        end
        chk({tag, "_stable"}, stab_err, 0);
    endtask

    initial begin
        strm.out_ready = 1'b0;

        // Reset values and basic stream with random consumer stalls
        do_reset();
        chk("rst_go", gen_go, 0);
        chk("rst_valid", strm.out_valid, 0);
        chk("rst_data", strm.out_data, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_count", count, 0);
        enable = 1'b1;
        for (int i = 0; i < 3000 && count != 8; i++) begin
            strm.out_ready = 1'($urandom_range(1, 0));
            tick(1);
        end
        enable = 1'b0;
        chk("basic_reach8", count, 8);
        strm.out_ready = 1'b1;
        tick(30);
        chk("basic_count", count, 8);
        chk("basic_go", go_cnt, 8);
        check_stream("basic", 8);

        // Backpressure: four pushes fill the FIFO, one pop admits exactly one more request
        g_lat_min = 1; g_lat_max = 3;
        strm.out_ready = 1'b0;
        do_reset();
        enable = 1'b1;
        tick(80);
        chk("bp_count", count, 4);
        chk("bp_go", go_cnt, 4);
        chk("bp_valid", strm.out_valid, 1);
        chk("bp_head", strm.out_data, 2);
        strm.out_ready = 1'b1;
        tick(1);
        strm.out_ready = 1'b0;
        tick(40);
        chk("bp_go_after", go_cnt, 5);
        chk("bp_count_after", count, 5);
        chk("bp_popped", got_q.size(), 1);
        enable = 1'b0;
        strm.out_ready = 1'b1;
        tick(10);
        check_stream("bp", 5);

        // Wrap-around of a 4-bit generator: 17 does not fit, generator returns 1
        g_lat_min = 1; g_lat_max = 5; g_limit = 15;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 2000 && !done; i++) begin
            strm.out_ready = 1'($urandom_range(1, 0));
            tick(1);
        end
        strm.out_ready = 1'b0;
        chk("wrap_done", done, 1);
        chk("wrap_error", error, 0);
        chk("wrap_count", count, 6);
        tick(30);
        chk("wrap_go", go_cnt, 7);
        strm.out_ready = 1'b1;
        tick(10);
        check_stream("wrap", 6);
        chk("wrap_drained", strm.out_valid, 0);
        g_limit = 65535;

        // Generator error on the third request
        g_err_req = 3;
        strm.out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 500 && !error; i++) tick(1);
        chk("err_error", error, 1);
        chk("err_done", done, 0);
        chk("err_count", count, 2);
        tick(30);
        chk("err_go", go_cnt, 3);
        strm.out_ready = 1'b1;
        tick(10);
        check_stream("err", 2);
        g_err_req = 0;

        // Enable dropped while the second request waits for its result
        g_lat_min = 4; g_lat_max = 4;
        strm.out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 200 && !(g_req == 2 && g_busy); i++) tick(1);
        chk("en_reach_req2", g_req, 2);
        tick(1);
        enable = 1'b0;
        tick(30);
        chk("en_count", count, 2);
        chk("en_go", go_cnt, 2);
        check_stream("en", 2);
        enable = 1'b1;
        for (int i = 0; i < 20 && go_cnt != 3; i++) tick(1);
        chk("en_resume_go", go_cnt, 3);

        // Reset in WAIT_RES with two entries buffered, then restart from 2
        strm.out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 200 && !(g_req == 3 && g_busy); i++) tick(1);
        tick(1);
        chk("mid_pre_count", count, 2);
        chk("mid_pre_valid", strm.out_valid, 1);
        do_reset();
        chk("mid_valid", strm.out_valid, 0);
        chk("mid_data", strm.out_data, 0);
        chk("mid_count", count, 0);
        chk("mid_go", gen_go, 0);
        chk("mid_done", done, 0);
        chk("mid_error", error, 0);
        strm.out_ready = 1'b1;
        for (int i = 0; i < 300 && count != 3; i++) tick(1);
        enable = 1'b0;
        tick(20);
        chk("mid_count_after", count, 3);
        check_stream("mid", 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
